// File: rtl/run_splitter.sv
// Splits a stream of zero-terminated runs alternately into merge inputs A and B.
// Zero latency: the pop and the write happen in the same cycle. Stalls while the target side is full.
module run_splitter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_empty,
  input  logic              i_in_done,
  output logic              o_in_rd,
  input  logic              i_a_full,
  input  logic              i_b_full,
  output logic              o_a_wr,
  output logic              o_b_wr,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_runs_a,
  output logic [CNT_W-1:0]  o_runs_b,
  output logic              o_finished,
  output logic              o_err_trunc
);

  typedef enum logic [2:0] {
    ROUTE_A  = 3'd0,
    ROUTE_B  = 3'd1,
    CLOSE    = 3'd2,
    PAD      = 3'd3,
    FINISHED = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic               close_b, close_b_nxt;
  logic [CNT_W-1:0]   elem_cnt, elem_nxt;
  logic [CNT_W-1:0]   runs_a_nxt, runs_b_nxt;
  logic               err_nxt;
  logic               cur_b;
  logic               cur_full;
  logic               close_full;
  logic               in_zero;

  assign cur_b      = (state == ROUTE_B);
  assign cur_full   = cur_b ? i_b_full : i_a_full;
  assign close_full = close_b ? i_b_full : i_a_full;
  assign in_zero    = (i_in_data == '0);
  assign o_finished = (state == FINISHED);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ROUTE_A;
      close_b     <= 1'b0;
      elem_cnt    <= '0;
      o_runs_a    <= '0;
      o_runs_b    <= '0;
      o_err_trunc <= 1'b0;
    end else begin
      state       <= state_nxt;
      close_b     <= close_b_nxt;
      elem_cnt    <= elem_nxt;
      o_runs_a    <= runs_a_nxt;
      o_runs_b    <= runs_b_nxt;
      o_err_trunc <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    close_b_nxt = close_b;
    elem_nxt    = elem_cnt;
    runs_a_nxt  = o_runs_a;
    runs_b_nxt  = o_runs_b;
    err_nxt     = o_err_trunc;
    o_in_rd     = 1'b0;
    o_a_wr      = 1'b0;
    o_b_wr      = 1'b0;
    o_data      = '0;

    case (state)
      ROUTE_A, ROUTE_B: begin
        if (!i_in_empty) begin
          if (!cur_full) begin
            o_in_rd = 1'b1;
            o_a_wr  = ~cur_b;
            o_b_wr  = cur_b;
            o_data  = i_in_data;
            if (in_zero) begin
              if (cur_b) runs_b_nxt = o_runs_b + 1'b1;
              else       runs_a_nxt = o_runs_a + 1'b1;
              elem_nxt  = '0;
              state_nxt = cur_b ? ROUTE_A : ROUTE_B;
            end else if (elem_cnt != '1) begin
              elem_nxt = elem_cnt + 1'b1;
            end
          end
        end else if (i_in_done) begin
          // Upstream is drained and closed: finish the open run or balance the sides.
          if (elem_cnt != '0) begin
            state_nxt   = CLOSE;
            close_b_nxt = cur_b;
            err_nxt     = 1'b1;
          end else if (o_runs_a > o_runs_b) begin
            state_nxt = PAD;
          end else begin
            state_nxt = FINISHED;
          end
        end
      end

      CLOSE: begin
        if (!close_full) begin
          o_a_wr   = ~close_b;
          o_b_wr   = close_b;
          elem_nxt = '0;
          if (close_b) runs_b_nxt = o_runs_b + 1'b1;
          else         runs_a_nxt = o_runs_a + 1'b1;
          state_nxt = (runs_a_nxt > runs_b_nxt) ? PAD : FINISHED;
        end
      end

      PAD: begin
        if (!i_b_full) begin
          o_b_wr     = 1'b1;
          runs_b_nxt = o_runs_b + 1'b1;
          state_nxt  = FINISHED;
        end
      end

      FINISHED: begin
        state_nxt = FINISHED;
      end

      default: begin
        state_nxt = ROUTE_A;
      end
    endcase

    // Reset wins in the cycle it is asserted: nothing moves through the FIFOs.
    if (i_rst) begin
      o_in_rd = 1'b0;
      o_a_wr  = 1'b0;
      o_b_wr  = 1'b0;
    end
  end

endmodule

// File: tb/tb_run_splitter.sv
// Scoreboard bench for run_splitter: a run-level reference model predicts the A/B streams and counts.
module tb_run_splitter;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  typedef logic [DATA_W-1:0] word_t;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [DATA_W-1:0] i_in_data;
  logic              i_in_empty;
  logic              i_in_done;
  logic              o_in_rd;
  logic              i_a_full;
  logic              i_b_full;
  logic              o_a_wr;
  logic              o_b_wr;
  logic [DATA_W-1:0] o_data;
  logic [CNT_W-1:0]  o_runs_a;
  logic [CNT_W-1:0]  o_runs_b;
  logic              o_finished;
  logic              o_err_trunc;

  run_splitter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_in_data(i_in_data), .i_in_empty(i_in_empty),
    .i_in_done(i_in_done), .o_in_rd(o_in_rd), .i_a_full(i_a_full), .i_b_full(i_b_full),
    .o_a_wr(o_a_wr), .o_b_wr(o_b_wr), .o_data(o_data), .o_runs_a(o_runs_a),
    .o_runs_b(o_runs_b), .o_finished(o_finished), .o_err_trunc(o_err_trunc)
  );

  always #5 i_clk = ~i_clk;

  word_t stim[$];
  word_t pending[$];
  word_t fifo_q[$];
  word_t exp_a[$];
  word_t exp_b[$];
  int    exp_ra, exp_rb;
  bit    exp_trunc;
  int    checks = 0;
  int    errors = 0;
  int    a_wr_cnt = 0;
  bit    popped = 0;
  bit    run_active = 0;
  bit    hold_active = 0;

  // Reference: cut the input into zero-terminated runs, deal them A,B,A,B...,
  // close a dangling run with a zero, and give B an empty run if it is one short.
  task automatic build_expect();
    word_t run[$];
    int nruns = 0;
    exp_a.delete();
    exp_b.delete();
    exp_trunc = 0;
    foreach (stim[i]) begin
      run.push_back(stim[i]);
      if (stim[i] == '0) begin
        foreach (run[j]) begin
          if (nruns % 2 == 0) exp_a.push_back(run[j]);
          else                exp_b.push_back(run[j]);
        end
        nruns++;
        run.delete();
      end
    end
    if (run.size() != 0) begin
      run.push_back('0);
      foreach (run[j]) begin
        if (nruns % 2 == 0) exp_a.push_back(run[j]);
        else                exp_b.push_back(run[j]);
      end
      nruns++;
      exp_trunc = 1;
    end
    exp_ra = (nruns + 1) / 2;
    exp_rb = nruns / 2;
    if (nruns % 2 == 1) begin
      exp_b.push_back('0);
      exp_rb++;
    end
  endtask

  task automatic tick(input int gap_pct, input int full_pct, input bit hold);
    @(negedge i_clk);
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (pending.size() > 0 && $urandom_range(0, 99) >= gap_pct)
      fifo_q.push_back(pending.pop_front());
    i_in_done   = run_active && (pending.size() == 0);
    i_in_empty  = (fifo_q.size() == 0);
    i_in_data   = i_in_empty ? word_t'($urandom) : fifo_q[0];
    hold_active = hold;
    i_a_full    = hold || ($urandom_range(0, 99) < full_pct);
    i_b_full    = ($urandom_range(0, 99) < full_pct);
  endtask

  always @(negedge i_clk) begin
    word_t e;
    #1;
    popped = o_in_rd;
    if (!i_rst) begin
      checks++;
      if ((o_a_wr && o_b_wr) || (o_a_wr && i_a_full) || (o_b_wr && i_b_full) ||
          (o_in_rd && (i_in_empty || !(o_a_wr || o_b_wr) || o_data != i_in_data))) begin
        errors++;
        $display("FAIL protocol: rd=%0b a_wr=%0b b_wr=%0b empty=%0b data=%h head=%h",
                 o_in_rd, o_a_wr, o_b_wr, i_in_empty, o_data, i_in_data);
      end
      if (hold_active) begin
        checks++;
        if (o_in_rd || o_a_wr) begin
          errors++;
          $display("FAIL hold_a: rd=%0b a_wr=%0b while A full, required 0/0", o_in_rd, o_a_wr);
        end
      end
      if (o_a_wr) begin
        checks++;
        a_wr_cnt++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL write_a: got %h, no write expected", o_data);
        end else begin
          e = exp_a.pop_front();
          if (o_data != e) begin
            errors++;
            $display("FAIL write_a: got %h, required %h", o_data, e);
          end
        end
      end
      if (o_b_wr) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL write_b: got %h, no write expected", o_data);
        end else begin
          e = exp_b.pop_front();
          if (o_data != e) begin
            errors++;
            $display("FAIL write_b: got %h, required %h", o_data, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    run_active = 0;
    hold_active = 0;
    fifo_q.delete();
    pending.delete();
    exp_a.delete();
    exp_b.delete();
    i_in_done = 0;
    i_in_empty = 1;
    i_in_data = '0;
    i_a_full = 0;
    i_b_full = 0;
    repeat (2) @(negedge i_clk);
    #2;
    check("rst_runs_a", int'(o_runs_a), 0);
    check("rst_runs_b", int'(o_runs_b), 0);
    check("rst_finished", int'(o_finished), 0);
    check("rst_err_trunc", int'(o_err_trunc), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic run_test(input string name, input int gap_pct, input int full_pct,
                          input int hold_a, input int stop_a);
    int cyc = 0;
    build_expect();
    pending = stim;
    a_wr_cnt = 0;
    run_active = 1;
    while (!o_finished && cyc < 3000 && !(stop_a > 0 && a_wr_cnt >= stop_a)) begin
      tick(gap_pct, full_pct, cyc < hold_a);
      cyc++;
    end
    if (stop_a > 0) return;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL %s timeout: finished=%0b after %0d cycles, required 1", name, o_finished, cyc);
    end
    repeat (3) tick(gap_pct, full_pct, 1'b0);
    check({name, "_a_left"}, exp_a.size(), 0);
    check({name, "_b_left"}, exp_b.size(), 0);
    check({name, "_runs_a"}, int'(o_runs_a), exp_ra);
    check({name, "_runs_b"}, int'(o_runs_b), exp_rb);
    check({name, "_trunc"}, int'(o_err_trunc), int'(exp_trunc));
    check({name, "_finished"}, int'(o_finished), 1);
    check({name, "_fifo_left"}, fifo_q.size(), 0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_in_done = 0;
    i_in_empty = 1;
    i_in_data = '0;
    i_a_full = 0;
    i_b_full = 0;
    do_reset();

    stim = '{32'd5, 32'd7, 32'd0, 32'd3, 32'd0, 32'd9, 32'd0};
    run_test("three_runs", 0, 0, 0, 0);
    do_reset();
    stim = '{32'd4, 32'd0, 32'd6, 32'd0};
    run_test("two_runs", 0, 0, 0, 0);
    do_reset();
    stim = '{32'd8, 32'd0};
    run_test("hold_a", 0, 0, 5, 0);
    do_reset();
    stim = '{32'd2, 32'd3};
    run_test("trunc", 0, 0, 0, 0);
    do_reset();
    stim = '{32'd0, 32'd1, 32'd0};
    run_test("empty_run", 0, 0, 0, 0);
    do_reset();

    stim = '{32'd5, 32'd7, 32'd0, 32'd3, 32'd0};
    run_test("mid_reset", 0, 0, 0, 1);
    do_reset();
    stim = '{32'd4, 32'd0};
    run_test("after_reset", 0, 0, 0, 0);
    do_reset();

    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(0, 24);
      stim.delete();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) stim.push_back('0);
        else                           stim.push_back(word_t'($urandom) | 32'd1);
      end
      run_test("random", $urandom_range(0, 50), $urandom_range(0, 50), 0, 0);
      do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
